prog_mem_loader: RTL



---
 rtl/prog_mem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - byte-stream loader filling program memory while holding the core in reset
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit additive checksum byte.
module prog_mem_loader #(
    parameter int PC_WIDTH   = 9,
    parameter int INST_WIDTH = 12,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic [INST_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold
);
    localparam logic [16:0] MaxCount = 17'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, CNT0, CNT1, LO, HI, WR, CHK, DONE} stateType;
`else
    typedef enum logic [2:0] {IDLE, CNT0, CNT1, LO, HI, WR, DONE} stateType;
`endif

    stateType    state, nextState;
    logic [7:0]  countLo;
    logic [7:0]  loByte;
    logic [15:0] remaining;
    logic [15:0] rxCount;
    logic        xfer;
    logic        countBad;
    logic        lastWord;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    assign xfer     = rx_valid && rx_ready;
    assign rxCount  = {rx_data, countLo};
    assign countBad = (rxCount == 16'd0) || ({1'b0, rxCount} > MaxCount);
    assign lastWord = (remaining == 16'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Byte-accepting states only look at rx_valid here, since rx_ready is 1 in all of them.
    always_comb begin
        nextState = state;
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nextState = CNT0;
            end
            CNT0: begin
                rx_ready = 1'b1;
                if (rx_valid) nextState = CNT1;
            end
            CNT1: begin
                rx_ready = 1'b1;
                if (rx_valid) nextState = countBad ? DONE : LO;
            end
            LO: begin
                rx_ready = 1'b1;
                if (rx_valid) nextState = HI;
            end
            HI: begin
                rx_ready = 1'b1;
                if (rx_valid) nextState = WR;
            end
            WR: begin
                mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                nextState = lastWord ? CHK : LO;
`else
                nextState = lastWord ? DONE : LO;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                rx_ready = 1'b1;
                if (rx_valid) nextState = DONE;
            end
`endif
            DONE: begin
                busy      = 1'b0;
                nextState = IDLE;
            end
            default: begin
                busy      = 1'b0;
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            countLo   <= 8'd0;
            loByte    <= 8'd0;
            remaining <= 16'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    cpu_hold <= 1'b1;
                    mem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
                    sum      <= 8'd0;
`endif
                end
                CNT0: if (xfer) countLo <= rx_data;
                CNT1: if (xfer) begin
                    remaining <= rxCount;
                    if (countBad) err <= 1'b1;
                end
                LO: if (xfer) begin
                    loByte <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                    sum    <= sum + rx_data;
`endif
                end
                HI: if (xfer) begin
                    mem_wdata <= {rx_data[INST_WIDTH-9:0], loByte};
`ifdef LOADER_CHECKSUM_EN
                    sum       <= sum + rx_data;
`endif
                end
                WR: begin
                    remaining <= remaining - 16'd1;
                    mem_addr  <= mem_addr + PC_WIDTH'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (xfer && (rx_data != sum)) err <= 1'b1;
`endif
                DONE: begin
                    done     <= !err;
                    cpu_hold <= err;
                end
                default: ;
            endcase
        end
    end
endmodule
